gfsk_modulation: RTL

//  BLE TX counterpart of the GFSK demodulator: turns a PHY bit stream into baseband I/Q.

---
 rtl/gfsk_modulation.sv | 120 ++++++++++++
 1 files changed

// File: rtl/gfsk_modulation.sv
// gfsk_modulation: BLE GFSK transmitter, PHY bit stream -> NRZ upsampling -> Gaussian FIR -> phase accumulator -> cos/sin lookup -> I/Q.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   bit_in, bit_valid, bit_ready  PHY bit handshake (transfer on bit_valid & bit_ready)
//   gauss_tap_we/addr/data        FIR tap write port (honoured only while idle)
//   cos_sin_we/addr, cos/sin_data cos/sin table write port (honoured only while idle)
//   i, q, iq_valid                registered signed baseband sample and its valid
//   busy                          high whenever a packet is running or draining
module gfsk_modulation #(
    parameter int SAMPLE_PER_SYMBOL      = 8,
    parameter int NUM_TAP_GAUSS_FILTER   = 17,
    parameter int GAUSS_FILTER_BIT_WIDTH = 16,
    parameter int VCO_BIT_WIDTH          = 16,
    parameter int SIN_COS_ADDR_BIT_WIDTH = 11,
    parameter int IQ_BIT_WIDTH           = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    bit_in,
    input  logic                                    bit_valid,
    output logic                                    bit_ready,
    input  logic                                    gauss_tap_we,
    input  logic [$clog2(NUM_TAP_GAUSS_FILTER)-1:0] gauss_tap_addr,
    input  logic [GAUSS_FILTER_BIT_WIDTH-1:0]       gauss_tap_data,
    input  logic                                    cos_sin_we,
    input  logic [SIN_COS_ADDR_BIT_WIDTH-1:0]       cos_sin_addr,
    input  logic [IQ_BIT_WIDTH-1:0]                 cos_data,
    input  logic [IQ_BIT_WIDTH-1:0]                 sin_data,
    output logic signed [IQ_BIT_WIDTH-1:0]          i,
    output logic signed [IQ_BIT_WIDTH-1:0]          q,
    output logic                                    iq_valid,
    output logic                                    busy
);
    localparam int NT = NUM_TAP_GAUSS_FILTER;
    localparam int VW = VCO_BIT_WIDTH;
    localparam int FL = NT + 3;
    localparam int CW = $clog2((SAMPLE_PER_SYMBOL > FL) ? SAMPLE_PER_SYMBOL : FL);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                             state, state_nxt;
    logic [CW-1:0]                      cnt, cnt_nxt;
    logic                               accept, last_sym, last_flush, v1, v2;
    logic signed [1:0]                  cur_nrz, shift_in;
    logic signed [1:0]                  x [NT];
    logic signed [GAUSS_FILTER_BIT_WIDTH-1:0] taps [NT];
    logic [VW-1:0]                      acc, fir, phase;
    logic [SIN_COS_ADDR_BIT_WIDTH-1:0]  addr;
    logic [IQ_BIT_WIDTH-1:0]            cos_tab [2**SIN_COS_ADDR_BIT_WIDTH];
    logic [IQ_BIT_WIDTH-1:0]            sin_tab [2**SIN_COS_ADDR_BIT_WIDTH];

    assign last_sym   = state == RUN && cnt == CW'(SAMPLE_PER_SYMBOL - 1);
    assign last_flush = state == FLUSH && cnt == CW'(FL - 1);
    assign bit_ready  = !rst && (state != RUN || last_sym);
    assign accept     = bit_valid && bit_ready;
    assign busy       = state != IDLE;
    assign addr       = phase[VW-1 -: SIN_COS_ADDR_BIT_WIDTH];
    // A newly accepted bit enters the shifter at once so consecutive bits leave no gap;
    // the last sample slot of a symbol without a successor already shifts zero.
    assign shift_in   = accept ? (bit_in ? 2'sb01 : 2'sb11) :
                        (state == RUN && !last_sym) ? cur_nrz : 2'sb00;

    always_comb begin
        state_nxt = accept ? RUN : last_sym ? FLUSH : last_flush ? IDLE : state;
        cnt_nxt   = (accept || last_sym || last_flush || state == IDLE) ? '0 : cnt + 1'b1;
    end

    // Only the low VW bits of the FIR sum feed the VCO, and modular arithmetic makes
    // them identical whether the sum is carried at full width or at VW bits.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NT; k++)
            acc = acc + VW'(taps[k]) * VW'(x[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_nrz  <= '0;
            fir      <= '0;
            phase    <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            iq_valid <= 1'b0;
            i        <= '0;
            q        <= '0;
            for (int k = 0; k < NT; k++) begin
                x[k]    <= '0;
                taps[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept)
                cur_nrz <= shift_in;
            x[0] <= shift_in;
            for (int k = 1; k < NT; k++)
                x[k] <= x[k-1];
            fir   <= acc;
            phase <= (state == IDLE && accept) ? '0 : phase + fir;
            v1       <= busy;
            v2       <= v1;
            iq_valid <= v2;
            if (v2) begin
                i <= cos_tab[addr];
                q <= sin_tab[addr];
            end
            if (gauss_tap_we && state == IDLE && int'(gauss_tap_addr) < NT)
                taps[gauss_tap_addr] <= gauss_tap_data;
        end
    end

    always_ff @(posedge clk) begin
        if (cos_sin_we && state == IDLE) begin
            cos_tab[cos_sin_addr] <= cos_data;
            sin_tab[cos_sin_addr] <= sin_data;
        end
    end
endmodule
